mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request capture to resp (legal 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning 32-bit words in backing array (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port imem_addr  input  32  instruction fetch byte address.
REQ-006 SHALL have port imem_rmask  input  4  fetch byte mask; nonzero = request this cycle.
REQ-007 SHALL have port imem_rdata  output  32  fetch data, valid with imem_resp.
REQ-008 SHALL have port imem_resp  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port dmem_addr  input  32  data byte address.
REQ-010 SHALL have port dmem_rmask  input  4  load byte mask; nonzero = load request.
REQ-011 SHALL have port dmem_wmask  input  4  store byte-lane mask; nonzero = store request.
REQ-012 SHALL have port dmem_wdata  input  32  store data, lane-aligned.
REQ-013 SHALL have port dmem_rdata  output  32  load data, valid with dmem_resp.
REQ-014 SHALL have port dmem_resp  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-016 Requests are single-cycle events; addr/mask/wdata SHALL be latched into a per-port pending register at the edge ending the request cycle.
REQ-017 Word index SHALL be addr[2 +: log2(DEPTH_WORDS)]; addr[1:0] and upper bits ignored (wrap-around).
REQ-018 Backing array single-ported; FSM states IDLE, SERVE_D, SERVE_I (enum mem_resp_state_t).
REQ-019 IDLE -> SERVE_D if dmem pending, else SERVE_I if imem pending; SERVE_x lasts exactly LATENCY cycles, down-counter loaded LATENCY-1.
REQ-020 Final SERVE_x cycle: resp=1, rdata = full stored word (rmask not applied); store commits wmask lanes at that edge; dmem store still pulses dmem_resp, dmem_rdata=0.
REQ-021 After final cycle SHALL go directly to the other port's SERVE if pending (dmem priority), else IDLE; no bubble.
REQ-022 Uncontended: request cycle T -> resp cycle T+LATENCY.
REQ-023 Simultaneous imem/dmem request at T: dmem_resp at T+LATENCY, imem_resp at T+2*LATENCY.
REQ-024 Store then fetch/load of same word SHALL return the stored value (served in order, dmem first when simultaneous).
REQ-025 New request on a port whose pending register is occupied SHALL be ignored and set proto_err (when checks enabled).
REQ-026 dmem_rmask and dmem_wmask both nonzero in one cycle SHALL be treated as store and set proto_err (when checks enabled).
REQ-027 rdata outputs SHALL hold last value between resp pulses.

Reset
REQ-028 rst_n low at an edge: state IDLE, counter 0, pending cleared, resp=0, rdata=0, proto_err=0.
REQ-029 Reset mid-service SHALL drop the transaction: no resp, no store commit; array contents SHALL NOT be reset.

Configuration
REQ-030 Macro MEM_RESPONDER_PROTO_CHECK_EN defined: REQ-025/026 detection drives proto_err, plus assertions on same conditions.
REQ-031 Macro undefined: proto_err tied 0, violations silently handled per REQ-025/026 data behaviour, no assertions.

Structure
REQ-032 mem_resp_state_t and a pending-request struct (addr, rmask, wmask, wdata, valid) SHALL live in rv32i_types.
REQ-033 Backing array SHALL be sub-module mem_responder_sram (1 read/write port, byte-lane write enable, synchronous write).
REQ-034 Target 150-300 lines RTL.

Verification (LATENCY=2 unless stated)
REQ-035 Store 0xDEADBEEF wmask 0xF addr 0x40 at T -> dmem_resp T+2; load addr 0x40 at T+3 -> dmem_rdata 0xDEADBEEF at T+5.
REQ-036 Store 0x000000AA wmask 0x1 to word 0x11223344 at addr 0x80 -> later load returns 0x112233AA.
REQ-037 imem addr 0x100 and dmem load addr 0x200 at T -> dmem_resp T+2, imem_resp T+4, exactly one pulse each.
REQ-038 DEPTH_WORDS=1024: store addr 0x1000 then fetch addr 0x0 -> fetch returns stored word (wrap).
REQ-039 rst_n low at T+1 during service of request at T -> no resp ever; prior array contents retained.
REQ-040 With MEM_RESPONDER_PROTO_CHECK_EN: second imem request at T+1 while first pending -> ignored, proto_err=1 from T+2 until reset; LATENCY=1 back-to-back loads at T,T+1 -> resps at T+1,T+2.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types: shared types for the mem_responder memory model.
//   mem_resp_state_t : responder FSM states (IDLE, SERVE_D, SERVE_I)
//   mem_pend_req_t   : one captured request (address, masks, store data, valid)
// No ports; imported by the responder files.
// ----------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } mem_resp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        valid;
  } mem_pend_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if: bundles the instruction-fetch and data ports of the
// memory responder.
//   master : the requester (drives addresses, masks, store data)
//   slave  : the responder (drives read data and completion pulses)
// ----------------------------------------------------------------------------
interface mem_responder_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  imem_rdata, imem_resp, dmem_rdata, dmem_resp
  );

  modport slave (
    input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_responder_sram.sv
// ----------------------------------------------------------------------------
// mem_responder_sram: single-port backing store of 32-bit words with per-byte
// write enables.
//   clk   : clock; writes happen on the rising edge
//   addr  : word index shared by read and write
//   we    : byte-lane write enables (bit n writes wdata[8n +: 8])
//   wdata : store data, lane aligned
//   rdata : word at addr (combinational read so a 1-cycle latency responder
//           can answer in the cycle right after capture)
// Contents are never reset.
// ----------------------------------------------------------------------------
module mem_responder_sram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     we,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder: fixed-latency memory model serving an instruction-fetch port
// and a data load/store port from one single-ported array.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset (array contents kept)
//   bus       : mem_responder_if.slave (imem_*/dmem_* request and response)
//   proto_err : sticky protocol-violation flag
// Parameters: LATENCY (1..15) cycles from capture to resp, DEPTH_WORDS (pow2).
// Build option: MEM_RESPONDER_PROTO_CHECK_EN enables proto_err detection and
// matching assertions; without it proto_err is tied low.
// ----------------------------------------------------------------------------
module mem_responder
  import rv32i_types::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus,
  output logic           proto_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mem_resp_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  mem_pend_req_t   d_pend_q, d_pend_d;
  mem_pend_req_t   i_pend_q, i_pend_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic [31:0]     i_rdata_q, i_rdata_d;

  logic        d_req, i_req, d_done, i_done, d_busy, i_busy;
  logic        d_resp, i_resp;
  logic [31:0] serve_addr, mem_rdata, d_word;
  logic [3:0]  mem_we;

  always_comb begin
    d_req  = (|bus.dmem_rmask) | (|bus.dmem_wmask);
    i_req  = |bus.imem_rmask;
    d_done = (state_q == SERVE_D) && (cnt_q == 4'd0);
    i_done = (state_q == SERVE_I) && (cnt_q == 4'd0);
    // A pending slot finishing this cycle is free to take a new request.
    d_busy = d_pend_q.valid && !d_done;
    i_busy = i_pend_q.valid && !i_done;

    d_pend_d = d_pend_q;
    if (d_done) d_pend_d.valid = 1'b0;
    if (d_req && !d_busy) begin
      d_pend_d = '{addr: bus.dmem_addr, rmask: bus.dmem_rmask, wmask: bus.dmem_wmask,
                   wdata: bus.dmem_wdata, valid: 1'b1};
    end

    i_pend_d = i_pend_q;
    if (i_done) i_pend_d.valid = 1'b0;
    if (i_req && !i_busy) begin
      i_pend_d = '{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: 4'h0,
                   wdata: 32'h0, valid: 1'b1};
    end
  end

  // Next state looks at the post-capture pending view, so a request arriving
  // while idle (or in a final serve cycle) starts service on the next edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (d_pend_d.valid) begin
          state_d = SERVE_D;
          cnt_d   = CNT_INIT;
        end else if (i_pend_d.valid) begin
          state_d = SERVE_I;
          cnt_d   = CNT_INIT;
        end
      end
      SERVE_D: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (i_pend_d.valid) begin
          state_d = SERVE_I;
          cnt_d   = CNT_INIT;
        end else if (d_pend_d.valid) begin
          state_d = SERVE_D;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      SERVE_I: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (d_pend_d.valid) begin
          state_d = SERVE_D;
          cnt_d   = CNT_INIT;
        end else if (i_pend_d.valid) begin
          state_d = SERVE_I;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Responses and store commits are suppressed while reset is asserted so an
  // interrupted transaction leaves no trace.
  always_comb begin
    serve_addr = (state_q == SERVE_I) ? i_pend_q.addr : d_pend_q.addr;
    d_resp     = d_done && rst_n;
    i_resp     = i_done && rst_n;
    mem_we     = d_resp ? d_pend_q.wmask : 4'h0;
    d_word     = (|d_pend_q.wmask) ? 32'h0 : mem_rdata;
    d_rdata_d  = d_resp ? d_word : d_rdata_q;
    i_rdata_d  = i_resp ? mem_rdata : i_rdata_q;
  end

  mem_responder_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .addr  (serve_addr[2 +: AW]),
    .we    (mem_we),
    .wdata (d_pend_q.wdata),
    .rdata (mem_rdata)
  );

  assign bus.dmem_resp  = d_resp;
  assign bus.imem_resp  = i_resp;
  assign bus.dmem_rdata = d_rdata_d;
  assign bus.imem_rdata = i_rdata_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      d_pend_q  <= '0;
      i_pend_q  <= '0;
      d_rdata_q <= 32'h0;
      i_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_pend_q  <= d_pend_d;
      i_pend_q  <= i_pend_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q
                | (d_req && d_busy)
                | (i_req && i_busy)
                | ((|bus.dmem_rmask) && (|bus.dmem_wmask));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) proto_err_q <= 1'b0;
    else        proto_err_q <= proto_err_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(d_req && d_busy)) else $warning("dmem request while dmem pending");
      assert (!(i_req && i_busy)) else $warning("imem request while imem pending");
      assert (!((|bus.dmem_rmask) && (|bus.dmem_wmask)))
        else $warning("dmem load and store masks both set");
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

  // Fields that are captured for completeness but never consulted.
  logic unused_bits;
  assign unused_bits = ^{d_pend_q.rmask, i_pend_q.rmask, i_pend_q.wmask,
                         i_pend_q.wdata, serve_addr[31:2+AW], serve_addr[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int L = 2;
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  localparam logic PROTO_ON = 1'b1;
`else
  localparam logic PROTO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst1_n, proto_err, proto_err1;
  mem_responder_if bus ();
  mem_responder_if bus1 ();

  mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .proto_err(proto_err)
  );
  mem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1), .proto_err(proto_err1)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       tag;
    logic        do_d;
    logic [31:0] d_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        do_i;
    logic [31:0] i_addr;
    logic [31:0] exp_d;
    logic [31:0] exp_i;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] ref_mem [16];   // model of pool words 0x300..0x30F

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.imem_addr = '0; bus.imem_rmask = '0;
    bus.dmem_addr = '0; bus.dmem_rmask = '0; bus.dmem_wmask = '0; bus.dmem_wdata = '0;
  endtask

  task automatic idle_bus1();
    bus1.imem_addr = '0; bus1.imem_rmask = '0;
    bus1.dmem_addr = '0; bus1.dmem_rmask = '0; bus1.dmem_wmask = '0; bus1.dmem_wdata = '0;
  endtask

  // Byte-lane merge: lanes selected by wm come from wd, the rest from old.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] wm,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (wm[k]) r[k*8 +: 8] = wd[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pool_addr(input int idx);
    return ((32'(idx) + 32'h300 + 32'h400 * 32'($urandom_range(0, 3))) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  // Issue one request (dmem, imem, or both in the same cycle) and watch a
  // fixed window, counting pulses and noting the first one's cycle and data.
  task automatic run_txn(input string tag, input logic do_d, input logic [31:0] d_addr,
                         input logic [3:0] rmask, input logic [3:0] wmask,
                         input logic [31:0] wdata, input logic do_i,
                         input logic [31:0] i_addr, input logic [31:0] exp_d,
                         input logic [31:0] exp_i);
    int d_cnt = 0, i_cnt = 0, d_lat = -1, i_lat = -1;
    logic [31:0] d_data = '0, i_data = '0;
    @(posedge clk); #1;
    if (do_d) begin
      bus.dmem_addr = d_addr; bus.dmem_rmask = rmask;
      bus.dmem_wmask = wmask; bus.dmem_wdata = wdata;
    end
    if (do_i) begin
      bus.imem_addr = i_addr; bus.imem_rmask = 4'hF;
    end
    for (int n = 0; n < 12; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (n == 1) idle_bus();
      end
      @(negedge clk);
      if (bus.dmem_resp === 1'b1) begin
        d_cnt++;
        if (d_cnt == 1) begin d_lat = n; d_data = bus.dmem_rdata; end
      end
      if (bus.imem_resp === 1'b1) begin
        i_cnt++;
        if (i_cnt == 1) begin i_lat = n; i_data = bus.imem_rdata; end
      end
    end
    $display("txn %s: dmem %0d pulse(s) @%0d data=%08h | imem %0d pulse(s) @%0d data=%08h",
             tag, d_cnt, d_lat, d_data, i_cnt, i_lat, i_data);
    if (do_d) begin
      chk({tag, " d_lat"}, 32'(d_lat), 32'(L));
      chk({tag, " d_pulses"}, 32'(d_cnt), 32'd1);
      chk({tag, " d_data"}, d_data, exp_d);
      chk({tag, " d_hold"}, bus.dmem_rdata, exp_d);
    end else begin
      chk({tag, " d_pulses"}, 32'(d_cnt), 32'd0);
    end
    if (do_i) begin
      chk({tag, " i_lat"}, 32'(i_lat), do_d ? 32'(2 * L) : 32'(L));
      chk({tag, " i_pulses"}, 32'(i_cnt), 32'd1);
      chk({tag, " i_data"}, i_data, exp_i);
      chk({tag, " i_hold"}, bus.imem_rdata, exp_i);
    end else begin
      chk({tag, " i_pulses"}, 32'(i_cnt), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, lat, cyc [2];
    logic [31:0] dat [2], data;
    logic        pe_t1, pe_t2;

    // ---------------- reset state ----------------
    rst_n = 1'b0; rst1_n = 1'b0;
    idle_bus(); idle_bus1();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    chk("rst dmem_resp", 32'(bus.dmem_resp), 32'd0);
    chk("rst imem_resp", 32'(bus.imem_resp), 32'd0);
    chk("rst dmem_rdata", bus.dmem_rdata, 32'h0);
    chk("rst imem_rdata", bus.imem_rdata, 32'h0);
    chk("rst proto_err", 32'(proto_err), 32'd0);
    chk("rst1 dmem_resp", 32'(bus1.dmem_resp), 32'd0);

    // ---------------- directed table ----------------
    vecs.push_back('{"st40",   1'b1, 32'h40,   4'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"ld40",   1'b1, 32'h40,   4'hF, 4'h0, 32'h0,        1'b0, 32'h0,   32'hDEADBEEF, 32'h0});
    vecs.push_back('{"st80",   1'b1, 32'h80,   4'h0, 4'hF, 32'h11223344, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"st80b",  1'b1, 32'h80,   4'h0, 4'h1, 32'h000000AA, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"ld80",   1'b1, 32'h80,   4'h1, 4'h0, 32'h0,        1'b0, 32'h0,   32'h112233AA, 32'h0});
    vecs.push_back('{"if80",   1'b0, 32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'h80,  32'h0,        32'h112233AA});
    vecs.push_back('{"st1000", 1'b1, 32'h1000, 4'h0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"if0",    1'b0, 32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'h0,   32'h0,        32'hCAFEF00D});
    vecs.push_back('{"st100",  1'b1, 32'h100,  4'h0, 4'hF, 32'h01010101, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"st200",  1'b1, 32'h200,  4'h0, 4'hF, 32'h02020202, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"pair",   1'b1, 32'h200,  4'hF, 4'h0, 32'h0,        1'b1, 32'h100, 32'h02020202, 32'h01010101});
    vecs.push_back('{"stif104",1'b1, 32'h104,  4'h0, 4'hF, 32'h0BADC0DE, 1'b1, 32'h104, 32'h0,        32'h0BADC0DE});
    vecs.push_back('{"ld103",  1'b1, 32'h103,  4'h8, 4'h0, 32'h0,        1'b0, 32'h0,   32'h01010101, 32'h0});
    vecs.push_back('{"st104m", 1'b1, 32'h104,  4'h0, 4'h6, 32'h00ABCD00, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"ld104",  1'b1, 32'h104,  4'hF, 4'h0, 32'h0,        1'b0, 32'h0,   32'h0BABCDDE, 32'h0});
    vecs.push_back('{"st1106", 1'b1, 32'h1106, 4'h0, 4'h3, 32'h00001234, 1'b0, 32'h0,   32'h0,        32'h0});
    vecs.push_back('{"if104",  1'b0, 32'h0,    4'h0, 4'h0, 32'h0,        1'b1, 32'h104, 32'h0,        32'h0BAB1234});
    foreach (vecs[k]) begin
      run_txn(vecs[k].tag, vecs[k].do_d, vecs[k].d_addr, vecs[k].rmask, vecs[k].wmask,
              vecs[k].wdata, vecs[k].do_i, vecs[k].i_addr, vecs[k].exp_d, vecs[k].exp_i);
    end

    // ---------------- randomized against the word model ----------------
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = $urandom;
      run_txn("init", 1'b1, pool_addr(k), 4'h0, 4'hF, ref_mem[k], 1'b0, 32'h0, 32'h0, 32'h0);
    end
    for (int k = 0; k < 30; k++) begin
      int          kind, a, b;
      logic [3:0]  m;
      logic [31:0] wd;
      kind = $urandom_range(0, 4);
      a    = $urandom_range(0, 15);
      b    = $urandom_range(0, 15);
      m    = 4'($urandom_range(1, 15));
      wd   = $urandom;
      case (kind)
        0: begin
          ref_mem[a] = merge(ref_mem[a], m, wd);
          run_txn("rnd_st", 1'b1, pool_addr(a), 4'h0, m, wd, 1'b0, 32'h0, 32'h0, 32'h0);
        end
        1: run_txn("rnd_ld", 1'b1, pool_addr(a), m, 4'h0, 32'h0, 1'b0, 32'h0, ref_mem[a], 32'h0);
        2: run_txn("rnd_if", 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 1'b1, pool_addr(a), 32'h0, ref_mem[a]);
        3: begin
          ref_mem[a] = merge(ref_mem[a], m, wd);
          run_txn("rnd_st_if", 1'b1, pool_addr(a), 4'h0, m, wd, 1'b1, pool_addr(b),
                  32'h0, ref_mem[b]);
        end
        default: run_txn("rnd_ld_if", 1'b1, pool_addr(a), m, 4'h0, 32'h0, 1'b1, pool_addr(b),
                         ref_mem[a], ref_mem[b]);
      endcase
    end

    // ---------------- reset during service drops the store ----------------
    cnt = 0;
    @(posedge clk); #1;
    bus.dmem_addr = 32'h40; bus.dmem_wmask = 4'hF; bus.dmem_wdata = 32'h55555555;
    @(posedge clk); #1;
    idle_bus(); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.dmem_resp === 1'b1) cnt++;
      @(posedge clk); #1;
    end
    $display("txn reset_mid_store: dmem %0d pulse(s)", cnt);
    chk("rstmid no_resp", 32'(cnt), 32'd0);
    run_txn("ld40_after_rst", 1'b1, 32'h40, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0);

    // ---------------- duplicate imem request while pending ----------------
    pulse_reset();
    cnt = 0; lat = -1; data = '0; pe_t1 = 1'b0; pe_t2 = 1'b0;
    @(posedge clk); #1;
    bus.imem_addr = 32'h100; bus.imem_rmask = 4'hF;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (n == 1) bus.imem_addr = 32'h40;
        if (n == 2) idle_bus();
      end
      @(negedge clk);
      if (n == 1) pe_t1 = proto_err;
      if (n == 2) pe_t2 = proto_err;
      if (bus.imem_resp === 1'b1) begin
        cnt++;
        if (cnt == 1) begin lat = n; data = bus.imem_rdata; end
      end
    end
    $display("txn dup_imem: imem %0d pulse(s) @%0d data=%08h proto_err=%0b", cnt, lat, data, proto_err);
    chk("dup i_pulses", 32'(cnt), 32'd1);
    chk("dup i_lat", 32'(lat), 32'(L));
    chk("dup i_data", data, 32'h01010101);
    chk("dup proto_t1", 32'(pe_t1), 32'd0);
    chk("dup proto_t2", 32'(pe_t2), 32'(PROTO_ON));
    chk("dup proto_sticky", 32'(proto_err), 32'(PROTO_ON));
    run_txn("both_masks", 1'b1, 32'h180, 4'hF, 4'hF, 32'h77777777, 1'b0, 32'h0, 32'h0, 32'h0);
    run_txn("ld180", 1'b1, 32'h180, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0, 32'h77777777, 32'h0);
    chk("both proto_err", 32'(proto_err), 32'(PROTO_ON));
    pulse_reset();
    @(negedge clk);
    chk("proto cleared", 32'(proto_err), 32'd0);

    // ---------------- LATENCY=1 back-to-back loads ----------------
    @(posedge clk); #1;
    bus1.dmem_addr = 32'h20; bus1.dmem_wmask = 4'hF; bus1.dmem_wdata = 32'h11110000;
    @(posedge clk); #1 idle_bus1();
    @(negedge clk);
    chk("l1 st20 resp", 32'(bus1.dmem_resp), 32'd1);
    @(posedge clk); #1;
    bus1.dmem_addr = 32'h24; bus1.dmem_wmask = 4'hF; bus1.dmem_wdata = 32'h22220000;
    @(posedge clk); #1 idle_bus1();
    @(negedge clk);
    chk("l1 st24 resp", 32'(bus1.dmem_resp), 32'd1);
    repeat (2) @(posedge clk);
    cnt = 0; cyc[0] = -1; cyc[1] = -1; dat[0] = '0; dat[1] = '0;
    #1;
    bus1.dmem_addr = 32'h20; bus1.dmem_rmask = 4'hF;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        if (n == 1) bus1.dmem_addr = 32'h24;
        if (n == 2) idle_bus1();
      end
      @(negedge clk);
      if (bus1.dmem_resp === 1'b1) begin
        if (cnt < 2) begin cyc[cnt] = n; dat[cnt] = bus1.dmem_rdata; end
        cnt++;
      end
    end
    $display("txn l1_b2b: %0d pulse(s) @%0d=%08h @%0d=%08h", cnt, cyc[0], dat[0], cyc[1], dat[1]);
    chk("l1 pulses", 32'(cnt), 32'd2);
    chk("l1 first_cyc", 32'(cyc[0]), 32'd1);
    chk("l1 first_data", dat[0], 32'h11110000);
    chk("l1 second_cyc", 32'(cyc[1]), 32'd2);
    chk("l1 second_data", dat[1], 32'h22220000);
    chk("l1 proto_err", 32'(proto_err1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
